// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the five-stage core hazard and flow controller:
// register index width, FSM state encoding and the scoreboard entry layout.
package pipe_hazard_ctrl_pkg;

    // Register index width (8 GPRs).
    localparam int REG_W = 3;

    // Controller state: normal flow, draining after HALT, fully halted.
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    // One in-flight destination: a valid flag plus the register it writes.
    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
    } sb_entry_t;

    // Entries that can raise a RAW hazard, bit 0 = EX, bit 1 = MEM, bit 2 = WB.
    // WB is excluded because the register file writes before it is read.
    localparam logic [2:0] HAZ_WINDOW = 3'b011;

    // Drain counter value on the last cycle HALT spends in MEM/WB.
    localparam logic [1:0] DRAIN_LAST = 2'd2;

endpackage

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// Three-entry in-flight destination scoreboard (EX, MEM, WB) mirroring the
// ID/EX, EX/MEM and MEM/WB registers, plus the decode-stage RAW compare.
module hazard_scoreboard
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             load_en,
    input  logic [REG_W-1:0] load_rd,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    output logic             raw
);

    // ent_p0 = EX, ent_p1 = MEM, ent_p2 = WB
    sb_entry_t ent_p0;
    sb_entry_t ent_p1;
    sb_entry_t ent_p2;

    logic [2:0] hit_rs;
    logic [2:0] hit_rt;

    function automatic logic entry_hit(input sb_entry_t e, input logic [REG_W-1:0] r);
        return e.valid && (e.rd == r);
    endfunction

    // Shift the in-flight destinations down the pipe whenever memory is ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ent_p0 <= '0;
            ent_p1 <= '0;
            ent_p2 <= '0;
        end else if (shift_en) begin
            ent_p2 <= ent_p1;
            ent_p1 <= ent_p0;
            if (load_en) begin
                ent_p0 <= '{valid: 1'b1, rd: load_rd};
            end else begin
                ent_p0 <= '0;
            end
        end
    end

    // Compare both decode sources against every entry inside the hazard window.
    always_comb begin
        hit_rs = {entry_hit(ent_p2, id_rs), entry_hit(ent_p1, id_rs), entry_hit(ent_p0, id_rs)};
        hit_rt = {entry_hit(ent_p2, id_rt), entry_hit(ent_p1, id_rt), entry_hit(ent_p0, id_rt)};
        raw    = id_valid &&
                 ((id_use_rs && (|(hit_rs & HAZ_WINDOW))) ||
                  (id_use_rt && (|(hit_rt & HAZ_WINDOW))));
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard and flow controller: drives the PC, IF/ID and ID/EX enables
// and flushes, stalls decode on RAW hazards, freezes on memory stalls, applies
// execute redirects, and drains then halts the core on HALT.
module pipe_hazard_ctrl #(
    parameter int REG_W = pipe_hazard_ctrl_pkg::REG_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_regwr,
    input  logic             id_halt,
    input  logic             ex_redirect,
    input  logic             mem_stall,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             later_en,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    import pipe_hazard_ctrl_pkg::*;

    state_t           state_q;
    state_t           state_d;
    logic [1:0]       drain_q;
    logic [CNT_W-1:0] stall_q;
    logic             raw;
    logic             issue;
    logic             load_en;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Decode issues only in RUN when nothing higher in priority holds it back.
    assign issue   = (state_q == ST_RUN) && !mem_stall && !ex_redirect && !raw;
    assign load_en = issue && id_valid && id_regwr;

    hazard_scoreboard u_sb (
        .clk       (clk),
        .rst       (rst),
        .shift_en  (!mem_stall),
        .load_en   (load_en),
        .load_rd   (id_rd),
        .id_valid  (id_valid),
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .id_use_rs (id_use_rs),
        .id_use_rt (id_use_rt),
        .raw       (raw)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: HALT issuing starts the drain; the drain ends once HALT
    // has left MEM/WB. A redirect blocks issue, so a squashed HALT never drains.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (issue && id_valid && id_halt) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!mem_stall && (drain_q == DRAIN_LAST)) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Drain counter: counts non-stalled cycles spent in DRAIN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drain_q <= 2'd0;
        end else if (state_q != ST_DRAIN) begin
            drain_q <= 2'd0;
        end else if (!mem_stall) begin
            drain_q <= (drain_q == DRAIN_LAST) ? 2'd0 : drain_q + 2'd1;
        end
    end

    // Saturating count of RUN cycles in which decode did not issue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
        end else if ((state_q == ST_RUN) && !issue) begin
            stall_q <= sat_inc(stall_q);
        end
    end

    assign stall_cnt = stall_q;

    // FSM outputs: priority mux over reset, halt, memory stall, drain,
    // redirect, RAW hazard and normal issue.
    always_comb begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        ifid_flush = 1'b0;
        idex_en    = 1'b0;
        idex_flush = 1'b0;
        later_en   = 1'b0;
        halted     = 1'b0;
        if (!rst) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (state_q == ST_HALT) begin
            halted = 1'b1;
        end else if (mem_stall) begin
            pc_en = 1'b0;
        end else if (state_q == ST_DRAIN) begin
            idex_en    = 1'b1;
            idex_flush = 1'b1;
            later_en   = 1'b1;
        end else if (ex_redirect) begin
            pc_en      = 1'b1;
            ifid_en    = 1'b1;
            ifid_flush = 1'b1;
            idex_en    = 1'b1;
            idex_flush = 1'b1;
            later_en   = 1'b1;
        end else if (raw) begin
            idex_en    = 1'b1;
            idex_flush = 1'b1;
            later_en   = 1'b1;
        end else begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            later_en = 1'b1;
        end
    end

endmodule
